fetch_branch_controller: RTL and testbench

Fetch-side partner of branch_resolution_unit, placed between IF and the IF/ID register. Detects a conditional branch in the fetched stream, raises branch_detected, and speculates not-taken while the branch is outstanding. Stalls on a second branch or when the speculation budget is exhausted. Consumes kill/resolve to either flush speculative instructions and redirect PC to the latched target, or commit them and return to normal fetch.

---
 rtl/fetch_branch_controller_pkg.sv | 22 ++
 rtl/fetch_branch_controller_predecode.sv | 27 ++
 rtl/fetch_branch_controller.sv | 167 ++++++++++++++++
 tb/tb_fetch_branch_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_branch_controller_pkg.sv
// Shared definitions for the fetch-side branch controller: opcode constant,
// controller state encoding and boolean helper macros.
`ifndef FBC_SYS_DEFS_SV
`define FBC_SYS_DEFS_SV

`define TRUE  1'b1
`define FALSE 1'b0

package sys_defs;

    // RV32 conditional branch major opcode (BEQ/BNE/BLT/BGE/BLTU/BGEU)
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        REDIRECT = 2'd2
    } fbc_state_t;

endpackage

`endif

// File: rtl/fetch_branch_controller_predecode.sv
// Combinational branch pre-decoder: flags RV32 conditional branches and
// computes the taken target from the B-type immediate. Kept stateless so a
// future BTB can reuse it on its own lookup path.
module branch_predecode
    import sys_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            is_br_o,
    output logic [XLEN-1:0] target_o
);

    logic signed [12:0]     imm_b;
    logic signed [XLEN-1:0] imm_sx;
    // rs1/rs2/funct3 do not affect detection or the target
    logic                   unused_fields;

    assign is_br_o       = (inst_i[6:0] == OP_BRANCH);
    assign imm_b         = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_sx        = {{(XLEN-13){imm_b[12]}}, imm_b};
    // Target wraps modulo 2^XLEN
    assign target_o      = pc_i + $unsigned(imm_sx);
    assign unused_fields = ^inst_i[24:12];

endmodule

// File: rtl/fetch_branch_controller.sv
// Fetch-side branch controller sitting between IF and the IF/ID register.
// Detects a conditional branch, speculates not-taken for up to MAX_SPEC
// instructions, and on kill/resolve either squashes and redirects to the
// latched target or commits and returns to normal fetch.
module fetch_branch_controller
    import sys_defs::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_SPEC = 8,
    parameter int CNT_W    = $clog2(MAX_SPEC + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    output logic             if_ready,
    input  logic             branch_pending,
    input  logic             kill,
    input  logic             resolve,
    output logic             branch_detected,
    output logic             dec_valid,
    output logic [XLEN-1:0]  dec_pc,
    output logic [31:0]      dec_inst,
    output logic             dec_spec,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] spec_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SPEC);

    fbc_state_t       state_q, state_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             first_q, first_d;

    logic             dec_valid_q;
    logic [XLEN-1:0]  dec_pc_q;
    logic [31:0]      dec_inst_q;
    logic             dec_spec_q;

    logic             is_br;
    logic [XLEN-1:0]  br_target;
    logic             accept;
    logic             accept_spec;
    logic             squash;
    logic             implicit_resolve;

    branch_predecode #(
        .XLEN (XLEN)
    ) u_predecode (
        .inst_i   (if_inst),
        .pc_i     (if_pc),
        .is_br_o  (is_br),
        .target_o (br_target)
    );

    // The resolution unit registers its state, so branch_pending cannot be
    // high in the first PENDING cycle. Seeing it low later with no kill or
    // resolve means the unit has already retired the branch: implicit resolve.
    assign implicit_resolve = !first_q && !branch_pending && !kill && !resolve;

    // Next-state, speculation bookkeeping and the combinational handshake outputs
    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        count_d         = count_q;
        first_d         = `FALSE;
        if_ready        = `FALSE;
        branch_detected = `FALSE;
        redirect_valid  = `FALSE;
        flush           = `FALSE;
        accept          = `FALSE;
        accept_spec     = `FALSE;
        squash          = `FALSE;

        unique case (state_q)
            IDLE: begin
                if_ready = `TRUE;
                if (if_valid) begin
                    accept = `TRUE;
                    if (is_br) begin
                        branch_detected = `TRUE;
                        target_d        = br_target;
                        count_d         = '0;
                        first_d         = `TRUE;
                        state_d         = PENDING;
                    end
                end
            end
            PENDING: begin
                // kill has priority over resolve; neither cycle accepts
                if (kill) begin
                    squash  = `TRUE;
                    state_d = REDIRECT;
                end else if (resolve || implicit_resolve) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    // A second branch is held at IF until this one settles
                    if_ready = !is_br && (count_q < MAX_CNT);
                    if (if_ready && if_valid) begin
                        accept      = `TRUE;
                        accept_spec = `TRUE;
                        count_d     = count_q + CNT_W'(1);
                    end
                end
            end
            REDIRECT: begin
                redirect_valid = `TRUE;
                flush          = `TRUE;
                squash         = `TRUE;
                count_d        = '0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, latched branch target and speculation counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            first_q  <= `FALSE;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            first_q  <= first_d;
        end
    end

    // IF/ID register: load on accept, bubble when ready without valid,
    // hold while stalled, clear when the speculative path is squashed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_valid_q <= `FALSE;
            dec_pc_q    <= '0;
            dec_inst_q  <= '0;
            dec_spec_q  <= `FALSE;
        end else if (squash) begin
            dec_valid_q <= `FALSE;
            dec_spec_q  <= `FALSE;
        end else if (if_ready) begin
            dec_valid_q <= accept;
            dec_spec_q  <= accept_spec;
            if (accept) begin
                dec_pc_q   <= if_pc;
                dec_inst_q <= if_inst;
            end
        end
    end

    assign dec_valid   = dec_valid_q;
    assign dec_pc      = dec_pc_q;
    assign dec_inst    = dec_inst_q;
    assign dec_spec    = dec_spec_q;
    assign redirect_pc = target_q;
    assign spec_count  = count_q;

endmodule

// File: tb/tb_fetch_branch_controller.sv
// Scoreboard bench for fetch_branch_controller: the stimulus thread pushes
// one hand-computed expectation per cycle; the monitor pops and compares it
// on the following falling edge.
module tb_fetch_branch_controller;

    localparam logic        H    = 1'b1;
    localparam logic        L    = 1'b0;
    localparam logic [31:0] BR20 = 32'h0200_0063;   // beq x0,x0,+0x20
    localparam logic [31:0] BRM8 = 32'hFE00_0CE3;   // beq x0,x0,-8
    localparam logic [31:0] NOP  = 32'h0000_0013;   // addi x0,x0,0

    logic        clock = 1'b1;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        branch_pending = 1'b0;
    logic        kill = 1'b0;
    logic        resolve = 1'b0;
    logic        if_ready;
    logic        branch_detected;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_spec;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [3:0]  spec_count;

    typedef struct {
        string       nm;
        logic        rdy;
        logic        bd;
        logic        dv;
        logic [31:0] dpc;
        logic [31:0] dinst;
        logic        ds;
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic [3:0]  cnt;
        logic        full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_branch_controller #(
        .XLEN     (32),
        .MAX_SPEC (8),
        .CNT_W    (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_ready        (if_ready),
        .branch_pending  (branch_pending),
        .kill            (kill),
        .resolve         (resolve),
        .branch_detected (branch_detected),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
        .dec_spec        (dec_spec),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .spec_count      (spec_count)
    );

    initial forever #5 clock = ~clock;

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic bp, input logic k, input logic r);
        if_valid       = v;
        if_pc          = pc;
        if_inst        = inst;
        branch_pending = bp;
        kill           = k;
        resolve        = r;
    endtask

    // Queue the expectation for the current cycle, then move past the next rising edge
    task automatic step(input string nm, input logic rdy, input logic bd, input logic dv,
                        input logic [31:0] dpc, input logic [31:0] dinst, input logic ds,
                        input logic rv, input logic [31:0] rpc, input logic fl,
                        input logic [3:0] cnt, input logic full);
        exp_t e;
        e.nm = nm;  e.rdy = rdy;  e.bd = bd;  e.dv = dv;  e.dpc = dpc;  e.dinst = dinst;
        e.ds = ds;  e.rv = rv;    e.rpc = rpc; e.fl = fl; e.cnt = cnt;  e.full = full;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        logic bad;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                bad = (if_ready !== e.rdy) || (branch_detected !== e.bd) || (dec_valid !== e.dv)
                    || (redirect_valid !== e.rv) || (flush !== e.fl) || (spec_count !== e.cnt);
                if (e.dv || e.full)
                    bad = bad || (dec_pc !== e.dpc) || (dec_inst !== e.dinst) || (dec_spec !== e.ds);
                if (e.rv || e.full)
                    bad = bad || (redirect_pc !== e.rpc);
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got rdy=%b bd=%b dv=%b pc=%h inst=%h spec=%b rv=%b rpc=%h fl=%b cnt=%0d; want rdy=%b bd=%b dv=%b pc=%h inst=%h spec=%b rv=%b rpc=%h fl=%b cnt=%0d",
                             e.nm, if_ready, branch_detected, dec_valid, dec_pc, dec_inst, dec_spec,
                             redirect_valid, redirect_pc, flush, spec_count,
                             e.rdy, e.bd, e.dv, e.dpc, e.dinst, e.ds, e.rv, e.rpc, e.fl, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] pp;
        logic [31:0] pi;

        #1;
        reset = 1'b1;
        step("reset", H, L, L, 32'h0, 32'h0, L, L, 32'h0, L, 4'd0, H);
        reset = 1'b0;

        // Branch at 0x100 (+0x20), three speculative instructions, resolve
        drv(H, 32'h100, BR20, L, L, L); step("br_detect",    H, H, L, 32'h0,   32'h0, L, L, 32'h0, L, 4'd0, L);
        drv(H, 32'h104, NOP,  H, L, L); step("br_in_ifid",   H, L, H, 32'h100, BR20,  L, L, 32'h0, L, 4'd0, L);
        drv(H, 32'h108, NOP,  H, L, L); step("spec1",        H, L, H, 32'h104, NOP,   H, L, 32'h0, L, 4'd1, L);
        drv(H, 32'h10C, NOP,  H, L, L); step("spec2",        H, L, H, 32'h108, NOP,   H, L, 32'h0, L, 4'd2, L);
        drv(H, 32'h110, NOP,  H, L, H); step("resolve",      L, L, H, 32'h10C, NOP,   H, L, 32'h0, L, 4'd3, L);
        drv(H, 32'h110, NOP,  L, L, L); step("post_resolve", H, L, H, 32'h10C, NOP,   H, L, 32'h0, L, 4'd0, L);
        drv(L, 32'h0,   NOP,  L, L, L); step("idle_accept",  H, L, H, 32'h110, NOP,   L, L, 32'h0, L, 4'd0, L);

        // Branch at 0x100, two speculative instructions, kill -> redirect to 0x120
        drv(H, 32'h100, BR20, L, L, L); step("k_detect",  H, H, L, 32'h0,   32'h0, L, L, 32'h0,   L, 4'd0, L);
        drv(H, 32'h104, NOP,  H, L, L); step("k_br",      H, L, H, 32'h100, BR20,  L, L, 32'h0,   L, 4'd0, L);
        drv(H, 32'h108, NOP,  H, L, L); step("k_spec1",   H, L, H, 32'h104, NOP,   H, L, 32'h0,   L, 4'd1, L);
        drv(H, 32'h10C, NOP,  H, H, L); step("kill",      L, L, H, 32'h108, NOP,   H, L, 32'h0,   L, 4'd2, L);
        drv(H, 32'h120, NOP,  L, L, L); step("redirect",  L, L, L, 32'h0,   32'h0, L, H, 32'h120, H, 4'd2, L);
        drv(H, 32'h120, NOP,  L, L, L); step("k_idle",    H, L, L, 32'h0,   32'h0, L, L, 32'h0,   L, 4'd0, L);
        drv(L, 32'h0,   NOP,  L, L, L); step("k_refetch", H, L, H, 32'h120, NOP,   L, L, 32'h0,   L, 4'd0, L);

        // Speculation budget: eight accepted, further fetch stalls until resolve
        drv(H, 32'h200, BR20, L, L, L); step("s_detect", H, H, L, 32'h0, 32'h0, L, L, 32'h0, L, 4'd0, L);
        for (int i = 1; i <= 8; i++) begin
            pp = 32'h200 + 32'(4 * (i - 1));
            pi = (i == 1) ? BR20 : NOP;
            drv(H, 32'h200 + 32'(4 * i), NOP, H, L, L);
            step("s_fill", H, L, H, pp, pi, (i != 1), L, 32'h0, L, 4'(i - 1), L);
        end
        drv(H, 32'h224, NOP, H, L, L); step("s_full",    L, L, H, 32'h220, NOP, H, L, 32'h0, L, 4'd8, L);
                                       step("s_hold",    L, L, H, 32'h220, NOP, H, L, 32'h0, L, 4'd8, L);
        drv(H, 32'h224, NOP, H, L, H); step("s_resolve", L, L, H, 32'h220, NOP, H, L, 32'h0, L, 4'd8, L);
        drv(H, 32'h224, NOP, L, L, L); step("s_release", H, L, H, 32'h220, NOP, H, L, 32'h0, L, 4'd0, L);
        drv(L, 32'h0,   NOP, L, L, L); step("s_ninth",   H, L, H, 32'h224, NOP, L, L, 32'h0, L, 4'd0, L);

        // Second branch at 0x108 (-8) is held, then detected in IDLE; kill shows target 0x100
        drv(H, 32'h100, BR20, L, L, L); step("d_detect",    H, H, L, 32'h0,   32'h0, L, L, 32'h0,   L, 4'd0, L);
        drv(H, 32'h104, NOP,  H, L, L); step("d_br",        H, L, H, 32'h100, BR20,  L, L, 32'h0,   L, 4'd0, L);
        drv(H, 32'h108, BRM8, H, L, L); step("d_second_br", L, L, H, 32'h104, NOP,   H, L, 32'h0,   L, 4'd1, L);
                                        step("d_hold",      L, L, H, 32'h104, NOP,   H, L, 32'h0,   L, 4'd1, L);
        drv(H, 32'h108, BRM8, H, L, H); step("d_resolve",   L, L, H, 32'h104, NOP,   H, L, 32'h0,   L, 4'd1, L);
        drv(H, 32'h108, BRM8, L, L, L); step("d_redetect",  H, H, H, 32'h104, NOP,   H, L, 32'h0,   L, 4'd0, L);
        drv(L, 32'h0,   NOP,  H, L, L); step("d_pend",      H, L, H, 32'h108, BRM8,  L, L, 32'h0,   L, 4'd0, L);
        drv(L, 32'h0,   NOP,  H, H, L); step("d_kill",      L, L, L, 32'h0,   32'h0, L, L, 32'h0,   L, 4'd0, L);
        drv(L, 32'h0,   NOP,  L, L, L); step("d_redirect",  L, L, L, 32'h0,   32'h0, L, H, 32'h100, H, 4'd0, L);
                                        step("d_idle",      H, L, L, 32'h0,   32'h0, L, L, 32'h0,   L, 4'd0, L);

        // kill and resolve together take the redirect path; target wraps past 2^32
        drv(H, 32'hFFFF_FFF0, BR20, L, L, L); step("w_detect",         H, H, L, 32'h0,         32'h0, L, L, 32'h0,  L, 4'd0, L);
        drv(H, 32'hFFFF_FFF4, NOP,  H, L, L); step("w_br",             H, L, H, 32'hFFFF_FFF0, BR20,  L, L, 32'h0,  L, 4'd0, L);
        drv(H, 32'hFFFF_FFF8, NOP,  H, H, H); step("kill_and_resolve", L, L, H, 32'hFFFF_FFF4, NOP,   H, L, 32'h0,  L, 4'd1, L);
        drv(L, 32'h0,         NOP,  L, L, L); step("w_redirect",       L, L, L, 32'h0,         32'h0, L, H, 32'h10, H, 4'd1, L);
                                              step("w_idle",           H, L, L, 32'h0,         32'h0, L, L, 32'h0,  L, 4'd0, L);

        // branch_pending never rises: second PENDING cycle acts as a resolve
        drv(H, 32'h300, BR20, L, L, L); step("f_detect",         H, H, L, 32'h0,   32'h0, L, L, 32'h0, L, 4'd0, L);
        drv(H, 32'h304, NOP,  L, L, L); step("f_first",          H, L, H, 32'h300, BR20,  L, L, 32'h0, L, 4'd0, L);
        drv(H, 32'h308, NOP,  L, L, L); step("implicit_resolve", L, L, H, 32'h304, NOP,   H, L, 32'h0, L, 4'd1, L);
                                        step("f_release",        H, L, H, 32'h304, NOP,   H, L, 32'h0, L, 4'd0, L);
        drv(L, 32'h0,   NOP,  L, L, L); step("f_accept",         H, L, H, 32'h308, NOP,   L, L, 32'h0, L, 4'd0, L);

        // Asynchronous reset in the middle of PENDING drops the branch
        drv(H, 32'h400, BR20, L, L, L); step("g_detect", H, H, L, 32'h0,   32'h0, L, L, 32'h0, L, 4'd0, L);
        drv(H, 32'h404, NOP,  H, L, L); step("g_br",     H, L, H, 32'h400, BR20,  L, L, 32'h0, L, 4'd0, L);
        drv(H, 32'h408, NOP,  H, L, L); step("g_spec",   H, L, H, 32'h404, NOP,   H, L, 32'h0, L, 4'd1, L);
        drv(L, 32'h0,   NOP,  L, L, L);
        reset = 1'b1;
        step("async_reset", H, L, L, 32'h0, 32'h0, L, L, 32'h0, L, 4'd0, H);
        reset = 1'b0;
        step("after_reset", H, L, L, 32'h0, 32'h0, L, L, 32'h0, L, 4'd0, H);
        drv(H, 32'h500, NOP, L, L, L); step("g_idle_accept", H, L, L, 32'h0,   32'h0, L, L, 32'h0, L, 4'd0, L);
        drv(L, 32'h0,   NOP, L, L, L); step("g_last",        H, L, H, 32'h500, NOP,   L, L, 32'h0, L, 4'd0, L);

        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
